// File: rtl/dlx_data_mem_bridge.sv
// dlx_data_mem_bridge
// Bridges the DLX data-memory port onto a single-outstanding request/ack bus.
// Stores are posted into a small in-order write buffer and drained in the
// background; loads wait for the buffer to drain before going to the bus.
//
// Handshake: the bus transaction is open while mem_req=1; mem_addr, mem_we
// and mem_wdata hold steady until the cycle mem_ack=1, which both completes
// the transfer and (for reads) qualifies mem_rdata. The processor side holds
// its request and operands stable for as long as cpu_stall=1.
//
// Optional build macro: DMEM_WBUF_FORWARD_EN -- loads that hit a buffered
// store are answered from the buffer (youngest match) without a bus access.
module dlx_data_mem_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd_en,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PW = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS} state_t;
  state_t state;

  // Write buffer storage; pointers carry one extra bit to tell full from empty
  logic [ADDR_WIDTH-1:0] wbuf_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] wbuf_data [WBUF_DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;

  logic wbuf_empty;
  logic wbuf_full;
  logic pop;
  logic push;
  logic load_req;
  logic fwd_take;

  assign wbuf_empty = (wr_ptr == rd_ptr);
  assign wbuf_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // The head entry retires only when the bus acknowledges its write
  assign pop  = (state == WR_BUS) && mem_ack;
  // A store into a full buffer still goes in if the head retires this cycle
  assign push = cpu_wr_en && (!wbuf_full || pop);

  // Store wins over a simultaneous load; the cycle carrying cpu_rvalid is the
  // completion cycle of the current load, so it is not a new request
  assign load_req = cpu_rd_en && !cpu_wr_en && !cpu_rvalid;

`ifdef DMEM_WBUF_FORWARD_EN
  logic [PW:0]           wbuf_count;
  logic [PW-1:0]         fwd_idx;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign wbuf_count = wr_ptr - rd_ptr;

  // Scan oldest to youngest so the last (youngest) match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      fwd_idx = rd_ptr[PW-1:0] + i[PW-1:0];
      if (((PW+1)'(i) < wbuf_count) && (wbuf_addr[fwd_idx] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wbuf_data[fwd_idx];
      end
    end
  end

  // A bus read in flight owns the load, so never forward on top of it
  assign fwd_take = load_req && fwd_hit && (state != RD_BUS);
`else
  assign fwd_take = 1'b0;
`endif

  // Stall a store only while it cannot be buffered; stall a load until its
  // data is returned
  assign cpu_stall = !rst && ((cpu_wr_en && wbuf_full && !pop) || load_req);

  // Buffer pointers, bus sequencing and load return in one registered block
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;

      if (push) begin
        wbuf_addr[wr_ptr[PW-1:0]] <= cpu_addr;
        wbuf_data[wr_ptr[PW-1:0]] <= cpu_wdata;
        wr_ptr                    <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

`ifdef DMEM_WBUF_FORWARD_EN
      if (fwd_take) begin
        cpu_rdata  <= fwd_data;
        cpu_rvalid <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (fwd_take) begin
            state <= IDLE;
          end else if (load_req && wbuf_empty) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cpu_addr;
            state    <= RD_BUS;
          end else if (!wbuf_empty) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wbuf_addr[rd_ptr[PW-1:0]];
            mem_wdata <= wbuf_data[rd_ptr[PW-1:0]];
            state     <= WR_BUS;
          end
        end
        WR_BUS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        RD_BUS: begin
          if (mem_ack) begin
            cpu_rdata  <= mem_rdata;
            cpu_rvalid <= 1'b1;
            mem_req    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
